// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: video/CPU/RAM signal bundle around the VRAM arbiter
// Ports (signals): ce slot strobe; vid_* ULA fetch port; cpu_* CPU port; mem_* VRAM macro port.
// Modports: slave = arbiter side, master = clients and RAM side.
interface vram_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 8
);
    logic          ce;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_valid;
    logic [DW-1:0] vid_data;
    logic          vid_miss;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          cpu_ack;
    logic [DW-1:0] cpu_dout;
    logic          cpu_wait;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    modport slave (
        input  ce, vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, mem_dout,
        output vid_valid, vid_data, vid_miss, cpu_ack, cpu_dout, cpu_wait, mem_addr, mem_we, mem_din
    );
    modport master (
        output ce, vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, mem_dout,
        input  vid_valid, vid_data, vid_miss, cpu_ack, cpu_dout, cpu_wait, mem_addr, mem_we, mem_din
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares single-port VRAM between ULA fetch (priority) and CPU, with starvation forcing
// Ports: clk_sys master clock; reset async active-high; bus (vram_arbiter_if.slave) carries
//   ce slot strobe, vid_req/vid_addr -> vid_valid/vid_data/vid_miss,
//   cpu_req/cpu_we/cpu_addr/cpu_din -> cpu_ack/cpu_dout/cpu_wait,
//   mem_addr/mem_we/mem_din -> RAM, mem_dout <- RAM (RD_LAT cycles after issue edge).
// Option: define VRAM_ARB_WRBUF_EN for a one-entry posted write buffer with read forwarding.
module vram_arbiter #(
    parameter int AW         = 15,
    parameter int DW         = 8,
    parameter int RD_LAT     = 1,
    parameter int MAX_STARVE = 4
) (
    input logic           clk_sys,
    input logic           reset,
    vram_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_STARVE + 2);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);
    logic [RD_LAT-1:0] pipe_v, pipe_cpu;
    logic [SW-1:0]     starve;
    logic              busy, done;
    logic              cpu_ok, c_req, c_we, pend, ack_now;
    logic              force_cpu, win_cpu, win_vid, out_v, out_cpu;
    logic [AW-1:0]     c_addr;
    logic [DW-1:0]     c_din;
    // A request is eligible until granted (busy) or acknowledged (done stays set while req is held).
    assign cpu_ok = bus.cpu_req & ~busy & ~done & ~bus.cpu_ack;
`ifdef VRAM_ARB_WRBUF_EN
    logic          wb_valid, wr_post, rd_hit;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    assign wr_post = cpu_ok & bus.cpu_we & ~wb_valid;
    assign rd_hit  = cpu_ok & ~bus.cpu_we & wb_valid & (bus.cpu_addr == wb_addr);
    // A pending buffer drains before any CPU read takes the slot.
    assign c_req   = wb_valid | (cpu_ok & ~bus.cpu_we & ~rd_hit);
    assign c_we    = wb_valid;
    assign c_addr  = wb_valid ? wb_addr : bus.cpu_addr;
    assign c_din   = wb_data;
    assign pend    = bus.cpu_req | wb_valid;
    assign ack_now = wr_post | rd_hit;
    always_ff @(posedge clk_sys or posedge reset)
        if (reset) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else if (wr_post) begin
            wb_valid <= 1'b1;
            wb_addr  <= bus.cpu_addr;
            wb_data  <= bus.cpu_din;
        end else if (win_cpu && wb_valid) begin
            wb_valid <= 1'b0;
        end
`else
    assign c_req   = cpu_ok;
    assign c_we    = bus.cpu_we;
    assign c_addr  = bus.cpu_addr;
    assign c_din   = bus.cpu_din;
    assign pend    = bus.cpu_req;
    assign ack_now = win_cpu & c_we;
`endif
    assign force_cpu    = (MAX_STARVE != 0) && (starve == STARVE_MAX) && c_req;
    assign win_cpu      = bus.ce & c_req & (force_cpu | ~bus.vid_req);
    assign win_vid      = bus.ce & bus.vid_req & ~win_cpu;
    assign out_v        = pipe_v[RD_LAT-1];
    assign out_cpu      = pipe_cpu[RD_LAT-1];
    assign bus.cpu_wait = bus.cpu_req & ~bus.cpu_ack & ~done;
    always_ff @(posedge clk_sys or posedge reset)
        if (reset) begin
            pipe_v        <= '0;
            pipe_cpu      <= '0;
            starve        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_din   <= '0;
            bus.vid_valid <= 1'b0;
            bus.vid_data  <= '0;
            bus.vid_miss  <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.cpu_dout  <= '0;
        end else begin
            pipe_v   <= (pipe_v << 1) | RD_LAT'(win_vid | (win_cpu & ~c_we));
            pipe_cpu <= (pipe_cpu << 1) | RD_LAT'(win_cpu & ~c_we);
            bus.mem_we   <= win_cpu & c_we;
            bus.vid_miss <= force_cpu & bus.ce & bus.vid_req;
            if (win_cpu) begin
                bus.mem_addr <= c_addr;
                bus.mem_din  <= c_din;
            end else if (win_vid) begin
                bus.mem_addr <= bus.vid_addr;
            end
            bus.vid_valid <= out_v & ~out_cpu;
            if (out_v && !out_cpu) bus.vid_data <= bus.mem_dout;
            bus.cpu_ack <= (out_v & out_cpu) | ack_now;
            if (out_v && out_cpu) bus.cpu_dout <= bus.mem_dout;
`ifdef VRAM_ARB_WRBUF_EN
            else if (rd_hit) bus.cpu_dout <= wb_data;
`endif
            // Only one CPU read may be outstanding; it clears when its data leaves the pipeline.
            if (win_cpu && !c_we) busy <= 1'b1;
            else if (out_v && out_cpu) busy <= 1'b0;
            done <= bus.cpu_req & (done | bus.cpu_ack);
            if (win_cpu || !pend) starve <= '0;
            else if (bus.ce && c_req && starve != STARVE_MAX) starve <= starve + 1'b1;
        end
endmodule
